// File: rtl/sdm_adc_aurora_pkg.sv
// Shared framing definitions for the SDM/ADC Aurora link (TX packer and RX aggregator).
// Provides frame/word size derivation, tag/payload layout and the TX FSM state type.
package sdm_adc_aurora_pkg;

    localparam int TAG_BIT   = 63;
    localparam int PAYLOAD_W = 63;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int calc_frame_w(
        input int nch_adc,
        input int adc_cyc,
        input int nch_sdm,
        input int sdm_cyc
    );
        return (adc_cyc / sdm_cyc) * nch_sdm * 2 + nch_adc * 16;
    endfunction

    function automatic int calc_nwords(input int frame_w);
        return (frame_w + PAYLOAD_W - 1) / PAYLOAD_W;
    endfunction

    function automatic int calc_last_bits(input int frame_w);
        return frame_w - PAYLOAD_W * (calc_nwords(frame_w) - 1);
    endfunction

endpackage

// File: rtl/sdm_adc_data_aurora_send_if.sv
// TX AXI-stream bundle toward the Aurora core user interface.
// Signals: tdata[63:0] word, tvalid word valid, tready core accepts word.
interface sdm_adc_data_aurora_send_if;

    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/sdm_adc_frame_fifo2.sv
// Two-entry frame FIFO with simultaneous push/pop and a synchronous flush.
// Ports: clk, rst, flush, push, pop, din; head/second entries, count, full, empty.
module sdm_adc_frame_fifo2 #(
    parameter int W = 510
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [W-1:0] second,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         push_ok;
    logic         pop_ok;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;
    assign head   = mem[rd_ptr];
    assign second = mem[~rd_ptr];

    // A pop in the same cycle frees the slot the push lands in.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sdm_adc_data_aurora_send.sv
// Packs one SDM/ADC frame per ADC period into 64-bit Aurora words, bit 63 tags the last word.
// Ports: CLK, RESET (sync, high), DIN/DIN_VALID frame in, CHANNEL_UP, s_axi_tx (master),
// FIFO_FULL, sticky OVERFLOW; FRAME_DROP_CNT[15:0] when SDM_ADC_AURORA_SEND_DROP_CNT_EN is defined.
module sdm_adc_data_aurora_send
    import sdm_adc_aurora_pkg::*;
#(
    parameter int NCH_ADC = 20,
    parameter int ADC_CYC = 20,
    parameter int NCH_SDM = 19,
    parameter int SDM_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [511:0]          DIN,
    input  logic                  DIN_VALID,
    input  logic                  CHANNEL_UP,
    sdm_adc_data_aurora_send_if.master s_axi_tx,
    output logic                  FIFO_FULL,
    output logic                  OVERFLOW
`ifdef SDM_ADC_AURORA_SEND_DROP_CNT_EN
    ,
    output logic [15:0]           FRAME_DROP_CNT
`endif
);

    localparam int FRAME_W   = calc_frame_w(NCH_ADC, ADC_CYC, NCH_SDM, SDM_CYC);
    localparam int NWORDS    = calc_nwords(FRAME_W);
    localparam int LAST_BITS = calc_last_bits(FRAME_W);
    localparam int EXT_W     = FRAME_W + (PAYLOAD_W - LAST_BITS);
    localparam int WCNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NWORDS - 1);

    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
    logic [63:0]         tdata_q;
    logic                tvalid_q;
    logic                overflow_q;

    logic [FRAME_W-1:0]  head_frame;
    logic [FRAME_W-1:0]  second_frame;
    logic [FRAME_W-1:0]  next_frame;
    logic [FRAME_W-1:0]  sel_frame;
    logic [EXT_W-1:0]    sel_ext;
    logic [WCNT_W-1:0]   sel_k;
    logic [63:0]         sel_word;
    logic [1:0]          fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic hs;
    logic wcnt_last;
    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic more;

    if (FRAME_W < 512) begin : g_unused
        logic unused_din;
        assign unused_din = ^DIN[511:FRAME_W];
    end

    assign s_axi_tx.tdata  = tdata_q;
    assign s_axi_tx.tvalid = tvalid_q;
    assign FIFO_FULL       = fifo_full;
    assign OVERFLOW        = overflow_q;

    assign hs        = (state == SEND) && tvalid_q && s_axi_tx.tready;
    assign wcnt_last = (wcnt == WCNT_LAST);
    assign pop       = hs && wcnt_last && CHANNEL_UP;
    assign push_req  = DIN_VALID && CHANNEL_UP;
    assign push      = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;

    // After a pop the new head is either the second entry or the frame
    // being pushed right now into a single-occupancy buffer.
    assign more       = (fifo_count == 2'd2) || ((fifo_count == 2'd1) && push);
    assign next_frame = (fifo_count == 2'd2) ? second_frame : DIN[FRAME_W-1:0];

    sdm_adc_frame_fifo2 #(
        .W (FRAME_W)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RESET),
        .flush  (!CHANNEL_UP),
        .push   (push),
        .pop    (pop),
        .din    (DIN[FRAME_W-1:0]),
        .head   (head_frame),
        .second (second_frame),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Word to load on the next transfer: the following word of the head
    // frame, or word 0 of whichever frame becomes current.
    always_comb begin
        sel_frame = head_frame;
        sel_k     = '0;
        if (hs && !wcnt_last) begin
            sel_k = wcnt + WCNT_W'(1);
        end else if (hs && wcnt_last) begin
            sel_frame = next_frame;
        end
        // Zero padding makes the unused upper bits of the last word 0.
        sel_ext  = EXT_W'(sel_frame);
        sel_word = '0;
        sel_word[PAYLOAD_W-1:0] = sel_ext[int'(sel_k) * PAYLOAD_W +: PAYLOAD_W];
        sel_word[TAG_BIT]       = (sel_k == WCNT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            wcnt     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else if (!CHANNEL_UP) begin
            state    <= IDLE;
            wcnt     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state    <= SEND;
                        wcnt     <= '0;
                        tdata_q  <= sel_word;
                        tvalid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (!wcnt_last) begin
                            wcnt    <= wcnt + WCNT_W'(1);
                            tdata_q <= sel_word;
                        end else if (more) begin
                            wcnt    <= '0;
                            tdata_q <= sel_word;
                        end else begin
                            state    <= IDLE;
                            wcnt     <= '0;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef SDM_ADC_AURORA_SEND_DROP_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            FRAME_DROP_CNT <= '0;
        end else if (drop && (FRAME_DROP_CNT != 16'hFFFF)) begin
            FRAME_DROP_CNT <= FRAME_DROP_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdm_adc_data_aurora_send.sv
// Self-checking bench for sdm_adc_data_aurora_send at default parameters.
// A queue-based frame model predicts every word, FIFO_FULL and OVERFLOW.
module tb_sdm_adc_data_aurora_send;

    localparam int FW = 510;
    localparam int NW = 9;
    typedef logic [FW-1:0] frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] din = '0;
    logic         din_valid = 1'b0;
    logic         chan_up = 1'b1;
    logic         fifo_full;
    logic         overflow;
`ifdef SDM_ADC_AURORA_SEND_DROP_CNT_EN
    logic [15:0]  drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    sdm_adc_data_aurora_send_if axi ();

    sdm_adc_data_aurora_send dut (
        .CLK        (clk),
        .RESET      (rst),
        .DIN        (din),
        .DIN_VALID  (din_valid),
        .CHANNEL_UP (chan_up),
        .s_axi_tx   (axi.master),
        .FIFO_FULL  (fifo_full),
        .OVERFLOW   (overflow)
`ifdef SDM_ADC_AURORA_SEND_DROP_CNT_EN
        ,
        .FRAME_DROP_CNT (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word k carries frame bits 63k.. upward; bit 63 flags the final word.
    function automatic logic [63:0] make_word(input frame_t f, input int k);
        frame_t s;
        s = f >> (63 * k);
        return {(k == NW - 1), s[62:0]};
    endfunction

    function automatic logic [511:0] rand_din();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    // Reference model: frames held by the link, word index of the head.
    frame_t      q[$];
    int          widx = 0;
    logic        exp_ovf = 1'b0;
    int          exp_drops = 0;
    logic        p_tv = 1'b0, p_tr = 1'b0, p_rst = 1'b1, p_cu = 1'b1;
    logic [63:0] p_data = '0;

    always @(negedge clk) begin
        check1("fifo_full", fifo_full, q.size() == 2);
        check1("overflow", overflow, exp_ovf);
        if (q.size() == 0) check1("tvalid_empty", axi.tvalid, 1'b0);
        if (p_tv && !p_tr && !p_rst && p_cu) begin
            check1("hold_tvalid", axi.tvalid, 1'b1);
            check64("hold_tdata", axi.tdata, p_data);
        end
        // Predict the effect of the coming rising edge.
        if (rst) begin
            q.delete();
            widx = 0;
            exp_ovf = 1'b0;
            exp_drops = 0;
        end else if (!chan_up) begin
            q.delete();
            widx = 0;
        end else begin
            if (axi.tvalid && axi.tready) begin
                if (q.size() == 0) begin
                    check1("spurious_word", axi.tvalid, 1'b0);
                end else begin
                    check64($sformatf("word%0d", widx), axi.tdata, make_word(q[0], widx));
                    widx++;
                    if (widx == NW) begin
                        void'(q.pop_front());
                        widx = 0;
                    end
                end
            end
            if (din_valid) begin
                if (q.size() < 2) q.push_back(din[FW-1:0]);
                else begin
                    exp_ovf = 1'b1;
                    exp_drops++;
                end
            end
        end
        p_tv = axi.tvalid;
        p_tr = axi.tready;
        p_rst = rst;
        p_cu = chan_up;
        p_data = axi.tdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rnd);
        repeat (n) begin
            if (rnd) axi.tready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic strobe(input logic [511:0] d);
        din = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2, 1'b0);
        rst = 1'b0;
    endtask

    logic [511:0] fa, fb;
    logic [63:0]  w8;

    initial begin
        axi.tready = 1'b1;
        idle(3, 1'b0);
        check64("rst_tdata", axi.tdata, 64'h0);
        check1("rst_tvalid", axi.tvalid, 1'b0);
        check1("rst_full", fifo_full, 1'b0);
        check1("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Known pattern frame, latency and first/last word layout.
        fa = '0;
        for (int i = 0; i < 56; i++) fa[63 + 8*i +: 8] = 8'(i + 1);
        fa[62:0] = '1;
        strobe(fa);
        check1("lat_tvalid0", axi.tvalid, 1'b0);
        tick();
        check1("lat_tvalid1", axi.tvalid, 1'b1);
        check64("word0_ones", axi.tdata, 64'h7FFF_FFFF_FFFF_FFFF);
        idle(8, 1'b0);
        w8 = '0;
        w8[63] = 1'b1;
        w8[5:0] = fa[509:504];
        check64("word8_tail", axi.tdata, w8);
        tick();
        check1("frame_end", axi.tvalid, 1'b0);
        idle(5, 1'b0);

        // Two back-to-back frames: 18 words without a bubble.
        strobe(rand_din());
        strobe(rand_din());
        for (int i = 0; i < 2 * NW; i++) begin
            check1("b2b_no_gap", axi.tvalid, 1'b1);
            tick();
        end
        check1("b2b_done", axi.tvalid, 1'b0);
        idle(5, 1'b0);

        // Periodic frames, ready always high.
        for (int f = 0; f < 1000; f++) begin
            strobe(rand_din());
            tick();
            for (int i = 0; i < NW; i++) begin
                check1("periodic_no_gap", axi.tvalid, 1'b1);
                tick();
            end
            idle(9, 1'b0);
        end
        check1("periodic_ovf", overflow, 1'b0);

        // Stall 45 cycles while three frames arrive: third is dropped.
        do_reset();
        axi.tready = 1'b0;
        strobe(rand_din());
        idle(19, 1'b0);
        strobe(rand_din());
        idle(19, 1'b0);
        strobe(rand_din());
        check1("stall_full", fifo_full, 1'b1);
        check1("stall_ovf", overflow, 1'b1);
`ifdef SDM_ADC_AURORA_SEND_DROP_CNT_EN
        vectors++;
        assert (drop_cnt === 16'd1) else begin
            miscompares++;
            $error("FAIL drop_cnt: observed %0d expected 1", drop_cnt);
        end
`endif
        idle(4, 1'b0);
        axi.tready = 1'b1;
        idle(30, 1'b0);
        check1("stall_drained", fifo_full, 1'b0);

        // Random back-pressure.
        do_reset();
        for (int f = 0; f < 100; f++) begin
            strobe(rand_din());
            idle(19, 1'b1);
        end
        axi.tready = 1'b1;
        idle(40, 1'b0);

        // Full buffer, push coincident with last-word handshake.
        do_reset();
        axi.tready = 1'b0;
        strobe(rand_din());
        idle(2, 1'b0);
        strobe(rand_din());
        idle(2, 1'b0);
        check1("coinc_full", fifo_full, 1'b1);
        axi.tready = 1'b1;
        idle(8, 1'b0);
        strobe(rand_din());
        check1("coinc_ovf", overflow, 1'b0);
        check1("coinc_still_full", fifo_full, 1'b1);
        idle(30, 1'b0);
        check1("coinc_ovf_end", overflow, 1'b0);

        // Channel drop at word 4, discards while down, restart at word 0.
        fa = rand_din();
        strobe(fa);
        idle(5, 1'b0);
        check64("cu_word4", axi.tdata, make_word(fa[FW-1:0], 4));
        chan_up = 1'b0;
        tick();
        check1("cu_tvalid", axi.tvalid, 1'b0);
        din_valid = 1'b1;
        idle(3, 1'b0);
        din_valid = 1'b0;
        check1("cu_no_ovf", overflow, 1'b0);
        check1("cu_empty", fifo_full, 1'b0);
        chan_up = 1'b1;
        idle(2, 1'b0);
        fb = rand_din();
        strobe(fb);
        tick();
        check64("cu_restart", axi.tdata, make_word(fb[FW-1:0], 0));
        idle(12, 1'b0);

        // Reset at word 4.
        fa = rand_din();
        strobe(fa);
        idle(5, 1'b0);
        rst = 1'b1;
        tick();
        check1("rst_mid_tvalid", axi.tvalid, 1'b0);
        rst = 1'b0;
        fb = rand_din();
        strobe(fb);
        tick();
        check64("rst_restart", axi.tdata, make_word(fb[FW-1:0], 0));
        idle(12, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
